// File: rtl/pattern_sequencer_if.sv
// rtl/pattern_sequencer_if.sv - control/status bundle between buttons, sync generator and the pattern sequencer
interface pattern_sequencer_if;
  logic       i_VSync;
  logic       i_Next;
  logic       i_Prev;
  logic       i_Mode_Toggle;
  logic [3:0] o_Pattern;
  logic       o_Auto;
  logic       o_Pending;
  logic       o_Frame_Start;

  modport slave (
    input  i_VSync,
    input  i_Next,
    input  i_Prev,
    input  i_Mode_Toggle,
    output o_Pattern,
    output o_Auto,
    output o_Pending,
    output o_Frame_Start
  );

  modport master (
    output i_VSync,
    output i_Next,
    output i_Prev,
    output i_Mode_Toggle,
    input  o_Pattern,
    input  o_Auto,
    input  o_Pending,
    input  o_Frame_Start
  );
endinterface

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - selects the test pattern number, changing it only at frame starts
module pattern_sequencer #(
  parameter int MIN_PATTERN        = 1,
  parameter int MAX_PATTERN        = 8,
  parameter int FRAMES_PER_PATTERN = 60
) (
  input  logic                i_Clk,
  input  logic                i_Reset,
  pattern_sequencer_if.slave  seq
);

  localparam int              CNT_W    = $clog2(FRAMES_PER_PATTERN + 1);
  localparam logic [3:0]      MIN_P    = 4'(MIN_PATTERN);
  localparam logic [3:0]      MAX_P    = 4'(MAX_PATTERN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAMES_PER_PATTERN - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_MANUAL = 2'd1,
    MODE_AUTO   = 2'd2
  } mode_t;

  mode_t            mode, mode_next;
  logic [3:0]       pattern, pattern_next;
  logic             pend_valid, pend_valid_next;
  logic             pend_up, pend_up_next;
  logic [CNT_W-1:0] frame_cnt, frame_cnt_next;
  logic             vsync_prev;
  logic             frame_start;
  logic             frame_start_q;
  logic             auto_q;
  logic             req_next;
  logic             req_prev;

  function automatic logic [3:0] step_up(input logic [3:0] p);
    return (p == MAX_P) ? MIN_P : p + 4'd1;
  endfunction

  function automatic logic [3:0] step_down(input logic [3:0] p);
    return (p == MIN_P) ? MAX_P : p - 4'd1;
  endfunction

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      mode          <= MODE_OFF;
      pattern       <= 4'd0;
      pend_valid    <= 1'b0;
      pend_up       <= 1'b0;
      frame_cnt     <= '0;
      vsync_prev    <= 1'b0;
      frame_start_q <= 1'b0;
      auto_q        <= 1'b0;
    end else begin
      mode          <= mode_next;
      pattern       <= pattern_next;
      pend_valid    <= pend_valid_next;
      pend_up       <= pend_up_next;
      frame_cnt     <= frame_cnt_next;
      vsync_prev    <= seq.i_VSync;
      frame_start_q <= frame_start;
      auto_q        <= (mode_next == MODE_AUTO);
    end
  end

  always_comb begin
    mode_next       = mode;
    pattern_next    = pattern;
    pend_valid_next = pend_valid;
    pend_up_next    = pend_up;
    frame_cnt_next  = frame_cnt;

    frame_start = seq.i_VSync & ~vsync_prev;
    req_next    = seq.i_Next & ~seq.i_Prev;
    req_prev    = seq.i_Prev & ~seq.i_Next;

    if (frame_start) begin
      if (mode == MODE_OFF) begin
        pattern_next = 4'd0;
      end else if (pattern == 4'd0) begin
        pattern_next    = MIN_P;
        pend_valid_next = 1'b0;
      end else if (pend_valid) begin
        pattern_next    = pend_up ? step_up(pattern) : step_down(pattern);
        pend_valid_next = 1'b0;
        if (mode == MODE_AUTO) begin
          frame_cnt_next = '0;
        end
      end else if (mode == MODE_AUTO) begin
        if (frame_cnt == LAST_CNT) begin
          pattern_next   = step_up(pattern);
          frame_cnt_next = '0;
        end else begin
          frame_cnt_next = frame_cnt + 1'b1;
        end
      end
    end

    // Evaluated after the frame-start update so a coincident request waits for the next frame.
    if (mode != MODE_OFF && (req_next || req_prev)) begin
      pend_valid_next = 1'b1;
      pend_up_next    = req_next;
    end

    if (seq.i_Mode_Toggle) begin
      case (mode)
        MODE_OFF:    mode_next = MODE_MANUAL;
        MODE_MANUAL: mode_next = MODE_AUTO;
        default:     mode_next = MODE_OFF;
      endcase
      pend_valid_next = 1'b0;
      frame_cnt_next  = '0;
    end
  end

  assign seq.o_Pattern     = pattern;
  assign seq.o_Auto        = auto_q;
  assign seq.o_Pending     = pend_valid;
  assign seq.o_Frame_Start = frame_start_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pattern_sequencer_if vif ();

  pattern_sequencer #(
    .MIN_PATTERN        (1),
    .MAX_PATTERN        (8),
    .FRAMES_PER_PATTERN (3)
  ) dut (
    .i_Clk   (clk),
    .i_Reset (rst),
    .seq     (vif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic nx, input logic pv, input logic tg);
    vif.i_Next        = nx;
    vif.i_Prev        = pv;
    vif.i_Mode_Toggle = tg;
    tick();
    vif.i_Next        = 1'b0;
    vif.i_Prev        = 1'b0;
    vif.i_Mode_Toggle = 1'b0;
  endtask

  task automatic fs_pulse(output logic [3:0] pat, output logic fsv);
    vif.i_VSync = 1'b1;
    tick();
    pat = vif.o_Pattern;
    fsv = vif.o_Frame_Start;
    vif.i_VSync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++;
    if (vif.o_Pattern !== 4'd0) begin n_fail++; $display("FAIL reset_pattern got=%0d exp=0", vif.o_Pattern); end
    n_checks++;
    if (vif.o_Auto !== 1'b0) begin n_fail++; $display("FAIL reset_auto got=%b exp=0", vif.o_Auto); end
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", vif.o_Pending); end
    n_checks++;
    if (vif.o_Frame_Start !== 1'b0) begin n_fail++; $display("FAIL reset_fs got=%b exp=0", vif.o_Frame_Start); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_enable();
    logic [3:0] pat;
    logic       fsv;
    pulse(1'b0, 1'b0, 1'b1);
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd1) begin n_fail++; $display("FAIL enable_pattern got=%0d exp=1", pat); end
    n_checks++;
    if (fsv !== 1'b1) begin n_fail++; $display("FAIL enable_fs_pulse got=%b exp=1", fsv); end
    n_checks++;
    if (vif.o_Frame_Start !== 1'b0) begin n_fail++; $display("FAIL enable_fs_single got=%b exp=0", vif.o_Frame_Start); end
    n_checks++;
    if (vif.o_Auto !== 1'b0) begin n_fail++; $display("FAIL enable_auto got=%b exp=0", vif.o_Auto); end
  endtask

  task automatic test_manual_wrap();
    logic [3:0] pat;
    logic       fsv;
    for (int i = 0; i < 7; i++) begin
      pulse(1'b1, 1'b0, 1'b0);
      fs_pulse(pat, fsv);
    end
    n_checks++;
    if (pat !== 4'd8) begin n_fail++; $display("FAIL manual_climb got=%0d exp=8", pat); end
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL manual_idle_pending got=%b exp=0", vif.o_Pending); end
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (vif.o_Pending !== 1'b1) begin n_fail++; $display("FAIL manual_pending_set got=%b exp=1", vif.o_Pending); end
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd1) begin n_fail++; $display("FAIL manual_wrap_up got=%0d exp=1", pat); end
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL manual_pending_clr got=%b exp=0", vif.o_Pending); end
    pulse(1'b0, 1'b1, 1'b0);
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd8) begin n_fail++; $display("FAIL manual_wrap_down got=%0d exp=8", pat); end
  endtask

  task automatic test_simultaneous();
    logic [3:0] pat;
    logic       fsv;
    pulse(1'b1, 1'b1, 1'b0);
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL simul_pending got=%b exp=0", vif.o_Pending); end
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd8) begin n_fail++; $display("FAIL simul_pattern got=%0d exp=8", pat); end
    pulse(1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd7) begin n_fail++; $display("FAIL overwrite_pattern got=%0d exp=7", pat); end
  endtask

  task automatic test_coincident();
    logic [3:0] pat;
    logic       fsv;
    vif.i_VSync = 1'b1;
    vif.i_Next  = 1'b1;
    tick();
    vif.i_Next  = 1'b0;
    n_checks++;
    if (vif.o_Pattern !== 4'd7) begin n_fail++; $display("FAIL coinc_held got=%0d exp=7", vif.o_Pattern); end
    n_checks++;
    if (vif.o_Pending !== 1'b1) begin n_fail++; $display("FAIL coinc_pending got=%b exp=1", vif.o_Pending); end
    vif.i_VSync = 1'b0;
    tick();
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd8) begin n_fail++; $display("FAIL coinc_applied got=%0d exp=8", pat); end
  endtask

  task automatic test_auto();
    logic [3:0] pat;
    logic       fsv;
    logic [3:0] exp_tbl [8] = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd3, 4'd4};
    pulse(1'b1, 1'b0, 1'b0);
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd1) begin n_fail++; $display("FAIL auto_start got=%0d exp=1", pat); end
    pulse(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (vif.o_Auto !== 1'b1) begin n_fail++; $display("FAIL auto_flag got=%b exp=1", vif.o_Auto); end
    for (int i = 0; i < 8; i++) begin
      if (i == 4) pulse(1'b1, 1'b0, 1'b0);
      fs_pulse(pat, fsv);
      n_checks++;
      if (pat !== exp_tbl[i]) begin n_fail++; $display("FAIL auto_fs%0d got=%0d exp=%0d", i + 1, pat, exp_tbl[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] pat;
    logic       fsv;
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (vif.o_Pending !== 1'b1) begin n_fail++; $display("FAIL mid_pending_pre got=%b exp=1", vif.o_Pending); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (vif.o_Pattern !== 4'd0) begin n_fail++; $display("FAIL mid_reset_pattern got=%0d exp=0", vif.o_Pattern); end
    n_checks++;
    if (vif.o_Auto !== 1'b0) begin n_fail++; $display("FAIL mid_reset_auto got=%b exp=0", vif.o_Auto); end
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL mid_reset_pending got=%b exp=0", vif.o_Pending); end
    pulse(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL off_ignores_req got=%b exp=0", vif.o_Pending); end
    pulse(1'b0, 1'b0, 1'b1);
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd1) begin n_fail++; $display("FAIL mid_reenable got=%0d exp=1", pat); end
    pulse(1'b1, 1'b0, 1'b1);
    n_checks++;
    if (vif.o_Pending !== 1'b0) begin n_fail++; $display("FAIL toggle_wins got=%b exp=0", vif.o_Pending); end
    n_checks++;
    if (vif.o_Auto !== 1'b1) begin n_fail++; $display("FAIL toggle_to_auto got=%b exp=1", vif.o_Auto); end
    pulse(1'b0, 1'b0, 1'b1);
    n_checks++;
    if (vif.o_Auto !== 1'b0) begin n_fail++; $display("FAIL toggle_to_off got=%b exp=0", vif.o_Auto); end
    fs_pulse(pat, fsv);
    n_checks++;
    if (pat !== 4'd0) begin n_fail++; $display("FAIL off_blank got=%0d exp=0", pat); end
    n_checks++;
    if (fsv !== 1'b1) begin n_fail++; $display("FAIL off_fs_pulse got=%b exp=1", fsv); end
  endtask

  initial begin
    vif.i_VSync       = 1'b0;
    vif.i_Next        = 1'b0;
    vif.i_Prev        = 1'b0;
    vif.i_Mode_Toggle = 1'b0;
    test_reset();
    test_enable();
    test_manual_wrap();
    test_simultaneous();
    test_coincident();
    test_auto();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
